// File: rtl/lsu_rmw.sv
`default_nettype none
// ============================================================================
// Module   : lsu_rmw
// Purpose  : Load/store initiator between the MEM stage and a word-only data
//            memory. Sub-word stores become read-modify-write sequences,
//            sub-word loads are sign/zero extended, and misaligned or
//            reserved-size requests are answered with an error response
//            without touching memory.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_rmw #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    // request side (MEM stage)
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_op,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [ADDR_W-1:0] req_pc,
    // response side
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    // word-only data memory
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    input  logic [31:0]       mem_rdata,
    output logic [ADDR_W-1:0] mem_pc
);

    // Access size encoding carried on req_op
    localparam logic [1:0] OP_WORD = 2'b00;
    localparam logic [1:0] OP_HALF = 2'b01;
    localparam logic [1:0] OP_BYTE = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD     = 3'd1,
        S_RMW_RD = 3'd2,
        S_WR     = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    state_t            state_q,      state_d;

    // Request fields captured in the accepting cycle
    logic [1:0]        op_q,         op_d;
    logic              we_q,         we_d;
    logic              signed_q,     signed_d;
    logic [ADDR_W-1:0] addr_q,       addr_d;
    logic [31:0]       wdata_q,      wdata_d;
    logic [ADDR_W-1:0] pc_q,         pc_d;

    // Registered outputs; mem_wdata_q doubles as the merge buffer
    logic [ADDR_W-1:0] mem_addr_q,   mem_addr_d;
    logic [31:0]       mem_wdata_q,  mem_wdata_d;
    logic              mem_we_q,     mem_we_d;
    logic [ADDR_W-1:0] mem_pc_q,     mem_pc_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_err_q,   resp_err_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;

    // Combinational helpers
    logic              req_misaligned;
    logic [7:0]        lane_byte;
    logic [15:0]       lane_half;
    logic [31:0]       load_ext;
    logic [31:0]       merged;

    // Alignment / reserved-size check on the raw request
    always_comb begin
        req_misaligned = 1'b0;
        case (req_op)
            OP_WORD: req_misaligned = (req_addr[1:0] != 2'b00);
            OP_HALF: req_misaligned = req_addr[0];
            OP_BYTE: req_misaligned = 1'b0;
            OP_RSVD: req_misaligned = 1'b1;
            default: req_misaligned = 1'b1;
        endcase
    end

    // Pick the addressed lane out of the read word and extend it
    always_comb begin
        lane_byte = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        lane_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (op_q)
            OP_BYTE: load_ext = {{24{signed_q & lane_byte[7]}}, lane_byte};
            OP_HALF: load_ext = {{16{signed_q & lane_half[15]}}, lane_half};
            default: load_ext = mem_rdata;
        endcase
    end

    // Overlay the store data onto the word read back for a sub-word store
    always_comb begin
        merged = mem_rdata;
        case (op_q)
            OP_BYTE: merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            OP_HALF: begin
                if (addr_q[1]) begin
                    merged[31:16] = wdata_q[15:0];
                end else begin
                    merged[15:0]  = wdata_q[15:0];
                end
            end
            default: merged = wdata_q;
        endcase
    end

    // Next-state and next-output logic; outputs are computed for the state
    // being entered so that they appear registered in that state's cycle
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        we_d         = we_q;
        signed_d     = signed_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        pc_d         = pc_q;
        mem_addr_d   = '0;
        mem_wdata_d  = 32'h0;
        mem_we_d     = 1'b0;
        mem_pc_d     = '0;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = resp_rdata_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d     = req_op;
                    we_d     = req_we;
                    signed_d = req_signed;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    pc_d     = req_pc;
                    if (req_misaligned) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 32'h0;
                    end else if (!req_we) begin
                        state_d    = S_RD;
                        mem_addr_d = {req_addr[ADDR_W-1:2], 2'b00};
                    end else if (req_op == OP_WORD) begin
                        state_d     = S_WR;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
                        mem_wdata_d = req_wdata;
                        mem_pc_d    = req_pc;
                    end else begin
                        state_d    = S_RMW_RD;
                        mem_addr_d = {req_addr[ADDR_W-1:2], 2'b00};
                    end
                end
            end
            S_RD: begin
                state_d      = S_RESP;
                resp_valid_d = 1'b1;
                resp_rdata_d = we_q ? 32'h0 : load_ext;
            end
            S_RMW_RD: begin
                state_d     = S_WR;
                mem_we_d    = 1'b1;
                mem_addr_d  = {addr_q[ADDR_W-1:2], 2'b00};
                mem_wdata_d = merged;
                mem_pc_d    = pc_q;
            end
            S_WR: begin
                state_d      = S_RESP;
                resp_valid_d = 1'b1;
                resp_rdata_d = 32'h0;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight request
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            op_q         <= 2'b00;
            we_q         <= 1'b0;
            signed_q     <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= 32'h0;
            pc_q         <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 32'h0;
            mem_we_q     <= 1'b0;
            mem_pc_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            we_q         <= we_d;
            signed_q     <= signed_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            pc_q         <= pc_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_we_q     <= mem_we_d;
            mem_pc_q     <= mem_pc_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_we     = mem_we_q;
    assign mem_pc     = mem_pc_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_rmw.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_rmw
// Purpose  : Self-checking bench for lsu_rmw. A transaction-level model
//            turns each accepted request into the list of per-cycle output
//            values it must produce; every cycle is compared against it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_rmw;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              req_valid, req_ready, req_we, req_signed;
    logic [1:0]        req_op;
    logic [ADDR_W-1:0] req_addr, req_pc;
    logic [31:0]       req_wdata;
    logic              resp_valid, resp_err;
    logic [31:0]       resp_rdata;
    logic [ADDR_W-1:0] mem_addr, mem_pc;
    logic [31:0]       mem_wdata, mem_rdata;
    logic              mem_we;

    lsu_rmw #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_op     (req_op),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_pc     (req_pc),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata),
        .mem_pc     (mem_pc)
    );

    always #5 clk = ~clk;

    // Word memory: combinational read, clocked write, plus a preload port
    logic [31:0] dmem [0:63];
    logic        pl_en = 1'b0;
    logic [5:0]  pl_idx = 6'd0;
    logic [31:0] pl_data = 32'h0;
    assign mem_rdata = dmem[mem_addr[7:2]];
    always @(posedge clk) begin
        if (pl_en) dmem[pl_idx] <= pl_data;
        else if (mem_we) dmem[mem_addr[7:2]] <= mem_wdata;
    end

    typedef struct packed {
        logic        rdy;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] pc;
        logic        rv;
        logic        re;
        logic [31:0] rd;
    } obs_t;

    logic [31:0] ref_mem [0:63];
    obs_t        expq [$];
    logic [31:0] last_rd = 32'h0;
    int          checks = 0;
    int          errors = 0;

    // Per-request observations, used for literal latency/value checks
    bit          obs_on = 1'b0;
    int          obs_cyc, seen_lat, we_cnt, we_lat;
    logic [31:0] seen_rd, we_wd, we_pc, we_addr;
    logic        seen_err;

    function automatic obs_t idle_rec();
        obs_t r;
        r = '0;
        r.rdy = 1'b1;
        r.rd  = last_rd;
        return r;
    endfunction

    task automatic pin(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, req);
        end
    endtask

    // Compare this cycle's outputs with the model's expectation
    task automatic check_cycle();
        obs_t act, exp;
        act = {req_ready, mem_we, mem_addr, mem_wdata, mem_pc, resp_valid, resp_err, resp_rdata};
        if (expq.size() != 0) exp = expq.pop_front();
        else exp = idle_rec();
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL cycle t=%0t rdy %0b/%0b we %0b/%0b addr %h/%h wd %h/%h pc %h/%h rv %0b/%0b err %0b/%0b rd %h/%h (actual/required)",
                     $time, act.rdy, exp.rdy, act.we, exp.we, act.addr, exp.addr, act.wd, exp.wd,
                     act.pc, exp.pc, act.rv, exp.rv, act.re, exp.re, act.rd, exp.rd);
        end
        if (exp.we) ref_mem[exp.addr[7:2]] = exp.wd;
        if (obs_on) begin
            obs_cyc++;
            if (mem_we) begin
                we_cnt++; we_lat = obs_cyc; we_wd = mem_wdata; we_pc = mem_pc; we_addr = mem_addr;
            end
            if (resp_valid) begin
                seen_lat = obs_cyc; seen_rd = resp_rdata; seen_err = resp_err;
            end
        end
    endtask

    // Expected output sequence for one accepted request
    task automatic model_accept(input logic we, input logic [1:0] op, input logic sgn,
                                input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] pc);
        obs_t        base, r;
        logic [31:0] word, val, mask, al;
        int          nbits, sh;
        bit          err;
        err   = (op == 2'd3) || (op == 2'd0 && addr[1:0] != 2'd0) || (op == 2'd1 && addr[0]);
        al    = addr & ~32'd3;
        word  = ref_mem[addr[7:2]];
        nbits = (op == 2'd2) ? 8 : ((op == 2'd1) ? 16 : 32);
        sh    = 8 * int'(addr[1:0]);
        base  = '0;
        base.rd = last_rd;
        if (err) begin
            r = base; r.rv = 1'b1; r.re = 1'b1; r.rd = 32'h0; expq.push_back(r);
            last_rd = 32'h0;
        end else if (!we) begin
            r = base; r.addr = al; expq.push_back(r);
            if (nbits < 32) begin
                val = (word >> sh) & ((32'd1 << nbits) - 32'd1);
                if (sgn && val >= (32'd1 << (nbits - 1))) val = val - (32'd1 << nbits);
            end else begin
                val = word;
            end
            r = base; r.rv = 1'b1; r.rd = val; expq.push_back(r);
            last_rd = val;
        end else begin
            if (nbits < 32) begin
                r = base; r.addr = al; expq.push_back(r);
                mask = ((32'd1 << nbits) - 32'd1) << sh;
                val  = (word & ~mask) | ((wd << sh) & mask);
            end else begin
                val = wd;
            end
            r = base; r.we = 1'b1; r.addr = al; r.wd = val; r.pc = pc; expq.push_back(r);
            r = base; r.rv = 1'b1; r.rd = 32'h0; expq.push_back(r);
            last_rd = 32'h0;
        end
    endtask

    task automatic drive_garbage(input bit allow_valid);
        req_valid  = allow_valid ? 1'($urandom_range(0, 1)) : 1'b0;
        req_we     = 1'($urandom_range(0, 1));
        req_op     = 2'($urandom_range(0, 3));
        req_signed = 1'($urandom_range(0, 1));
        req_addr   = $urandom;
        req_wdata  = $urandom;
        req_pc     = $urandom;
    endtask

    task automatic drive_req(input logic we, input logic [1:0] op, input logic sgn,
                             input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] pc);
        req_valid = 1'b1; req_we = we; req_op = op; req_signed = sgn;
        req_addr = addr; req_wdata = wd; req_pc = pc;
        model_accept(we, op, sgn, addr, wd, pc);
    endtask

    // Called at the negedge of an idle cycle, after it was checked; returns
    // at the negedge of the next idle cycle, after it was checked
    task automatic issue(input logic we, input logic [1:0] op, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] pc);
        obs_on = 1'b1; obs_cyc = 0; seen_lat = -1; we_cnt = 0; we_lat = -1;
        seen_rd = 32'h0; seen_err = 1'b0; we_wd = 32'h0; we_pc = 32'h0; we_addr = 32'h0;
        drive_req(we, op, sgn, addr, wd, pc);
        for (int i = 0; i < 8 && expq.size() != 0; i++) begin
            @(negedge clk);
            check_cycle();
            drive_garbage(1'b1);
        end
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL sequence-timeout actual %0d pending required 0", expq.size());
            expq.delete();
        end
        @(negedge clk);
        check_cycle();
        drive_garbage(1'b0);
        obs_on = 1'b0;
    endtask

    initial begin
        logic [31:0] v;
        drive_garbage(1'b0);
        #1;
        check_cycle();                       // reset state
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            v = $urandom;
            if (i == 4)  v = 32'h8899AABB;
            if (i == 8)  v = 32'h11223344;
            if (i == 20) v = 32'hCAFEF00D;
            pl_en = 1'b1; pl_idx = 6'(i); pl_data = v; ref_mem[i] = v;
        end
        @(negedge clk);
        pl_en = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check_cycle();

        issue(1'b0, 2'd2, 1'b1, 32'h13, 32'h0, 32'h100);
        pin("lb-signed-rdata", seen_rd, 32'hFFFFFF88);
        pin("lb-latency", 32'(seen_lat), 32'd2);
        pin("lb-no-write", 32'(we_cnt), 32'd0);

        issue(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 32'h104);
        pin("lhu-rdata", seen_rd, 32'h00008899);
        issue(1'b0, 2'd1, 1'b1, 32'h10, 32'h0, 32'h108);
        pin("lh-signed-rdata", seen_rd, 32'hFFFFAABB);

        issue(1'b1, 2'd2, 1'b0, 32'h21, 32'hFFFFFFA5, 32'h200);
        pin("sb-write-count", 32'(we_cnt), 32'd1);
        pin("sb-write-cycle", 32'(we_lat), 32'd2);
        pin("sb-write-addr", we_addr, 32'h20);
        pin("sb-merged", we_wd, 32'h1122A544);
        pin("sb-resp-latency", 32'(seen_lat), 32'd3);
        pin("sb-resp-err", 32'(seen_err), 32'd0);

        issue(1'b1, 2'd0, 1'b0, 32'h30, 32'hDEADBEEF, 32'h3008);
        pin("sw-write-cycle", 32'(we_lat), 32'd1);
        pin("sw-wdata", we_wd, 32'hDEADBEEF);
        pin("sw-pc", we_pc, 32'h3008);
        pin("sw-resp-latency", 32'(seen_lat), 32'd2);

        issue(1'b0, 2'd0, 1'b0, 32'h42, 32'h0, 32'h300);
        pin("lw-mis-err", 32'(seen_err), 32'd1);
        pin("lw-mis-latency", 32'(seen_lat), 32'd1);
        pin("lw-mis-rdata", seen_rd, 32'h0);
        issue(1'b1, 2'd1, 1'b0, 32'h45, 32'h1234, 32'h304);
        pin("sh-mis-err", 32'(seen_err), 32'd1);
        pin("sh-mis-no-write", 32'(we_cnt), 32'd0);
        issue(1'b1, 2'd3, 1'b0, 32'h40, 32'h5555, 32'h308);
        pin("op11-err", 32'(seen_err), 32'd1);
        pin("op11-latency", 32'(seen_lat), 32'd1);
        pin("op11-no-write", 32'(we_cnt), 32'd0);

        // Leave a non-zero resp_rdata behind, then reset mid read-modify-write
        issue(1'b0, 2'd0, 1'b0, 32'h10, 32'h0, 32'h400);
        pin("lw-rdata", seen_rd, 32'h8899AABB);
        drive_req(1'b1, 2'd2, 1'b0, 32'h51, 32'h77, 32'h500);
        @(negedge clk);
        check_cycle();                       // RMW_RD cycle
        drive_garbage(1'b0);
        #2 reset = 1'b1;
        #1;
        pin("rst-mem_we", 32'(mem_we), 32'd0);
        pin("rst-resp_valid", 32'(resp_valid), 32'd0);
        pin("rst-mem_addr", mem_addr, 32'h0);
        pin("rst-resp_rdata", resp_rdata, 32'h0);
        expq.delete();
        last_rd = 32'h0;
        @(negedge clk);
        check_cycle();
        reset = 1'b0;
        @(negedge clk);
        check_cycle();
        pin("rst-ready", 32'(req_ready), 32'd1);
        pin("rst-mem-untouched", dmem[20], 32'hCAFEF00D);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                check_cycle();
                drive_garbage(1'b0);
            end
            issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  32'($urandom_range(0, 255)), $urandom, $urandom);
        end

        @(negedge clk);
        check_cycle();
        for (int i = 0; i < 64; i++) pin("final-mem", dmem[i], ref_mem[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
